pb_interrupt_ctrl: RTL and testbench



---
 rtl/pb_interrupt_ctrl.sv | 79 +++++++
 tb/tb_pb_interrupt_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pb_interrupt_ctrl.sv
// pb_interrupt_ctrl: edge-latched, maskable interrupt sequencer for the KCPSM6 interrupt/interrupt_ack pins.
module pb_interrupt_ctrl #(
  parameter int         NUM_SRC    = 4,
  parameter logic [7:0] MASK_PORT  = 8'h04,
  parameter logic [7:0] CLEAR_PORT = 8'h05,
  parameter logic [7:0] CAUSE_PORT = 8'h03,
  parameter logic [7:0] PEND_PORT  = 8'h06,
  parameter logic [7:0] MISS_PORT  = 8'h07
) (
  input  logic               board_clk,
  input  logic               Reset,
  input  logic [NUM_SRC-1:0] src_level,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  input  logic               write_strobe,
  input  logic               read_strobe,
  input  logic               interrupt_ack,
  output logic               interrupt,
  output logic [7:0]         rd_data,
  output logic               rd_hit
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE, HOLDOFF} state_t;
  state_t state_q, state_d;
  logic [NUM_SRC-1:0] src_q, edg_q, mask_q, mask_d, pend_q, pend_d, cause_q, cause_d, set_ev, pm;
  logic [7:0] miss_q, miss_d;
  logic mask_wr, clr_wr, miss_rd, miss_hit, unused_ok;
  assign mask_wr   = write_strobe && port_id == MASK_PORT;
  assign clr_wr    = write_strobe && port_id == CLEAR_PORT;
  assign miss_rd   = read_strobe && port_id == MISS_PORT;
  assign interrupt = state_q == REQ;
  assign unused_ok = ^out_port;
  always_comb begin
    set_ev   = edg_q & mask_q;
    pm       = pend_q & mask_q;
    mask_d   = mask_wr ? out_port[NUM_SRC-1:0] : mask_q;
    pend_d   = (pend_q & ~(clr_wr ? out_port[NUM_SRC-1:0] : '0)) | set_ev;
    miss_hit = |(set_ev & pend_q);
    miss_d   = miss_rd ? {7'd0, miss_hit} : miss_q + {7'd0, miss_hit && miss_q != 8'hFF};
    cause_d  = cause_q;
    state_d  = state_q;
    case (state_q)
      IDLE:    state_d = |pm ? REQ : IDLE;
      REQ: begin
        // a request whose enabled pending bits vanished before ack is withdrawn
        state_d = !(|pm) ? IDLE : interrupt_ack ? SERVICE : REQ;
        cause_d = (|pm && interrupt_ack) ? pm : cause_q;
      end
      SERVICE: state_d = clr_wr ? HOLDOFF : SERVICE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge board_clk) begin
    if (Reset) begin
      src_q   <= src_level;
      edg_q   <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      cause_q <= '0;
      miss_q  <= '0;
      state_q <= IDLE;
    end else begin
      src_q   <= src_level;
      edg_q   <= src_level & ~src_q;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      cause_q <= cause_d;
      miss_q  <= miss_d;
      state_q <= state_d;
    end
  end
  always_comb begin
    rd_data = port_id == MASK_PORT  ? 8'(mask_q)  :
              port_id == CAUSE_PORT ? 8'(cause_q) :
              port_id == PEND_PORT  ? 8'(pend_q)  :
              port_id == MISS_PORT  ? miss_q      : 8'h00;
    rd_hit  = port_id == MASK_PORT || port_id == CAUSE_PORT ||
              port_id == PEND_PORT || port_id == MISS_PORT;
  end
endmodule

// File: tb/tb_pb_interrupt_ctrl.sv
// tb_pb_interrupt_ctrl: directed scenarios for the PicoBlaze interrupt controller.
module tb_pb_interrupt_ctrl;
  logic clk = 0, Reset = 1;
  logic [3:0] src_level = '0;
  logic [7:0] port_id = '0, out_port = '0, rd_data;
  logic write_strobe = 0, read_strobe = 0, interrupt_ack = 0, interrupt, rd_hit;
  int checks = 0, errors = 0;
  logic [7:0] v;

  pb_interrupt_ctrl #(.NUM_SRC(4)) dut (
    .board_clk(clk), .Reset(Reset), .src_level(src_level), .port_id(port_id),
    .out_port(out_port), .write_strobe(write_strobe), .read_strobe(read_strobe),
    .interrupt_ack(interrupt_ack), .interrupt(interrupt), .rd_data(rd_data), .rd_hit(rd_hit)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    port_id = p; out_port = d; write_strobe = 1;
    tick();
    write_strobe = 0; out_port = '0; port_id = '0;
  endtask

  task automatic peek(input logic [7:0] p, output logic [7:0] d);
    port_id = p;
    #1 d = rd_data;
    port_id = '0;
  endtask

  task automatic rd_clr(input logic [7:0] p, output logic [7:0] d);
    port_id = p; read_strobe = 1;
    #1 d = rd_data;
    tick();
    read_strobe = 0; port_id = '0;
  endtask

  task automatic do_reset();
    Reset = 1;
    tick(2);
    Reset = 0;
  endtask

  task automatic pulse0();
    src_level[0] = 0;
    tick();
    src_level[0] = 1;
    tick();
  endtask

  task automatic test_reset();
    src_level = 4'b0000;
    do_reset();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", interrupt); end
    peek(8'h04, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_mask got=%h exp=00", v); end
    peek(8'h06, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_pend got=%h exp=00", v); end
    peek(8'h03, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_cause got=%h exp=00", v); end
    peek(8'h07, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_miss got=%h exp=00", v); end
  endtask

  task automatic test_masked();
    src_level[0] = 1; tick(2); src_level[0] = 0;
    interrupt_ack = 1; tick(); interrupt_ack = 0;
    tick(3);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL masked_irq got=%b exp=0", interrupt); end
    peek(8'h06, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL masked_pend got=%h exp=00", v); end
    peek(8'h07, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL masked_miss got=%h exp=00", v); end
    peek(8'h03, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL stray_ack_cause got=%h exp=00", v); end
    wr(8'h03, 8'hFF);
    peek(8'h03, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL ro_cause_write got=%h exp=00", v); end
  endtask

  task automatic test_ports();
    wr(8'h04, 8'h0B);
    peek(8'h04, v); checks++; if (v !== 8'h0B) begin errors++; $display("FAIL mask_rb got=%h exp=0b", v); end
    port_id = 8'h05; #1;
    checks++; if (rd_hit !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("FAIL clear_port_hit got=%b/%h exp=0/00", rd_hit, rd_data); end
    port_id = 8'h06; #1;
    checks++; if (rd_hit !== 1'b1) begin errors++; $display("FAIL pend_port_hit got=%b exp=1", rd_hit); end
    port_id = 8'h02; #1;
    checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL other_port_hit got=%b exp=0", rd_hit); end
    port_id = '0;
    wr(8'h04, 8'h00);
  endtask

  task automatic test_latency();
    do_reset();
    wr(8'h04, 8'h01);
    src_level[0] = 1;
    tick();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL lat_n1 got=%b exp=0", interrupt); end
    tick();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL lat_n2 got=%b exp=0", interrupt); end
    tick();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL lat_n3 got=%b exp=1", interrupt); end
    tick();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL lat_n4 got=%b exp=1", interrupt); end
    tick();
    interrupt_ack = 1;
    tick();
    interrupt_ack = 0;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL ack_n6 got=%b exp=0", interrupt); end
    peek(8'h03, v); checks++; if (v !== 8'h01) begin errors++; $display("FAIL cause_01 got=%h exp=01", v); end
    wr(8'h05, 8'h01);
    peek(8'h06, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL pend_cleared got=%h exp=00", v); end
    tick(3);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL post_clear_irq got=%b exp=0", interrupt); end
    src_level[0] = 0;
  endtask

  task automatic test_multi();
    do_reset();
    wr(8'h04, 8'h0F);
    src_level = 4'b1010;
    tick(3);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL multi_irq got=%b exp=1", interrupt); end
    peek(8'h06, v); checks++; if (v !== 8'h0A) begin errors++; $display("FAIL multi_pend got=%h exp=0a", v); end
    interrupt_ack = 1; tick(); interrupt_ack = 0;
    peek(8'h03, v); checks++; if (v !== 8'h0A) begin errors++; $display("FAIL multi_cause got=%h exp=0a", v); end
    src_level = 4'b1110;
    tick(2);
    peek(8'h06, v); checks++; if (v !== 8'h0E) begin errors++; $display("FAIL svc_pend got=%h exp=0e", v); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL svc_irq got=%b exp=0", interrupt); end
    wr(8'h05, 8'h0A);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL holdoff_c0 got=%b exp=0", interrupt); end
    tick();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL holdoff_c1 got=%b exp=0", interrupt); end
    tick();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL reassert_c2 got=%b exp=1", interrupt); end
    peek(8'h06, v); checks++; if (v !== 8'h04) begin errors++; $display("FAIL reassert_pend got=%h exp=04", v); end
    src_level = '0;
  endtask

  task automatic test_missed();
    do_reset();
    wr(8'h04, 8'h01);
    src_level[0] = 1;
    tick(2);
    for (int i = 0; i < 3; i++) pulse0();
    tick(2);
    rd_clr(8'h07, v); checks++; if (v !== 8'h03) begin errors++; $display("FAIL miss_3 got=%h exp=03", v); end
    rd_clr(8'h07, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL miss_clr got=%h exp=00", v); end
    for (int i = 0; i < 300; i++) pulse0();
    tick(2);
    peek(8'h07, v); checks++; if (v !== 8'hFF) begin errors++; $display("FAIL miss_sat got=%h exp=ff", v); end
    pulse0();
    rd_clr(8'h07, v); checks++; if (v !== 8'hFF) begin errors++; $display("FAIL miss_sat_rd got=%h exp=ff", v); end
    peek(8'h07, v); checks++; if (v !== 8'h01) begin errors++; $display("FAIL miss_clr_inc got=%h exp=01", v); end
    src_level = '0;
  endtask

  task automatic test_withdraw();
    do_reset();
    wr(8'h04, 8'h01);
    src_level[0] = 1;
    tick(3);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL wd_req got=%b exp=1", interrupt); end
    wr(8'h04, 8'h00);
    tick();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL wd_drop got=%b exp=0", interrupt); end
    tick(2);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL wd_idle got=%b exp=0", interrupt); end
    wr(8'h04, 8'h01);
    tick();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL wd_rearm got=%b exp=1", interrupt); end
    src_level = '0;
  endtask

  task automatic test_reset_in_service();
    do_reset();
    wr(8'h04, 8'h01);
    src_level[0] = 1;
    tick(3);
    interrupt_ack = 1; tick(); interrupt_ack = 0;
    peek(8'h03, v); checks++; if (v !== 8'h01) begin errors++; $display("FAIL rs_cause_pre got=%h exp=01", v); end
    Reset = 1; tick(); Reset = 0;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rs_irq got=%b exp=0", interrupt); end
    peek(8'h03, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL rs_cause got=%h exp=00", v); end
    peek(8'h04, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL rs_mask got=%h exp=00", v); end
    wr(8'h04, 8'h01);
    tick(5);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rs_no_edge got=%b exp=0", interrupt); end
    peek(8'h06, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL rs_pend got=%h exp=00", v); end
    src_level[0] = 0; tick();
    src_level[0] = 1; tick(3);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL rs_new_edge got=%b exp=1", interrupt); end
    src_level = '0;
  endtask

  initial begin
    test_reset();
    test_masked();
    test_ports();
    test_latency();
    test_multi();
    test_missed();
    test_withdraw();
    test_reset_in_service();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
